// File: rtl/vip_gray_rank_filter_3x3_if.sv
// Gray pixel stream bundle: frame sync, line valid, pixel strobe and pixel value.
`timescale 1ns/1ps
interface vip_gray_rank_filter_3x3_if #(
  parameter int DW = 8
);
  logic          frame_vsync;
  logic          frame_href;
  logic          frame_clken;
  logic [DW-1:0] img;

  modport master (output frame_vsync, frame_href, frame_clken, img);
  modport slave  (input  frame_vsync, frame_href, frame_clken, img);
endinterface

// File: rtl/vip_gray_rank_filter_3x3.sv
// 3x3 rank filter (median / erode / dilate / bypass) on a gray pixel stream,
// with its own two line buffers and a fixed 4-clk input-to-output latency.
`timescale 1ns/1ps
module vip_gray_rank_filter_3x3 #(
  parameter int DW        = 8,
  parameter int IMG_WIDTH = 640,
  parameter int LAT       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode,
  vip_gray_rank_filter_3x3_if.slave         pe,
  vip_gray_rank_filter_3x3_if.master        pos,
  output logic [1:0]                        cur_mode
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  typedef logic [DW-1:0] pix_t;

  if (LAT != 4) begin : g_lat_check
    $error("vip_gray_rank_filter_3x3: only LAT=4 is implemented");
  end

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t mid3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic          adv, vs_rise, href_fall;
  logic          vsync_d, href_d, frame_ok;
  logic [10:0]   row_cnt;
  logic [CW-1:0] col_cnt;

  assign adv       = pe.frame_clken & pe.frame_href;
  assign vs_rise   = pe.frame_vsync & ~vsync_d;
  assign href_fall = href_d & ~pe.frame_href;

  // frame_ok keeps every window a border window after reset until a fresh frame starts
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      frame_ok <= 1'b0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      cur_mode <= '0;
    end else begin
      vsync_d <= pe.frame_vsync;
      href_d  <= pe.frame_href;
      if (vs_rise) begin
        cur_mode <= mode;
        frame_ok <= 1'b1;
        row_cnt  <= '0;
      end else if (href_fall && row_cnt != 11'd2047) begin
        row_cnt <= row_cnt + 11'd1;
      end
      if (href_fall)
        col_cnt <= '0;
      else if (adv)
        col_cnt <= col_cnt + CW'(1);
    end
  end

  // ---- S1: line buffers and window capture ----
  pix_t line0 [IMG_WIDTH];
  pix_t line1 [IMG_WIDTH];
  pix_t p11, p12, p13, p21, p22, p23, p31, p32, p33;
  pix_t img_p1;
  logic vs_p1, hr_p1, vld_p1, bdr_p1;

  always_ff @(posedge clk) begin
    img_p1 <= pe.img;
    if (adv) begin
      line0[0] <= pe.img;
      line1[0] <= line0[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        line0[i] <= line0[i-1];
        line1[i] <= line1[i-1];
      end
      p11 <= p12;  p12 <= p13;  p13 <= line1[IMG_WIDTH-1];
      p21 <= p22;  p22 <= p23;  p23 <= line0[IMG_WIDTH-1];
      p31 <= p32;  p32 <= p33;  p33 <= pe.img;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_p1  <= 1'b0;
      hr_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      bdr_p1 <= 1'b0;
    end else begin
      vs_p1  <= pe.frame_vsync;
      hr_p1  <= pe.frame_href;
      vld_p1 <= pe.frame_clken;
      bdr_p1 <= ~frame_ok | (row_cnt < 11'd2) | (col_cnt < CW'(2));
    end
  end

  // ---- S2: per-row sort ----
  pix_t hi_p2 [3];
  pix_t md_p2 [3];
  pix_t lo_p2 [3];
  pix_t img_p2;
  logic vs_p2, hr_p2, vld_p2, bdr_p2;

  always_ff @(posedge clk) begin
    img_p2   <= img_p1;
    hi_p2[0] <= max3(p11, p12, p13);
    md_p2[0] <= mid3(p11, p12, p13);
    lo_p2[0] <= min3(p11, p12, p13);
    hi_p2[1] <= max3(p21, p22, p23);
    md_p2[1] <= mid3(p21, p22, p23);
    lo_p2[1] <= min3(p21, p22, p23);
    hi_p2[2] <= max3(p31, p32, p33);
    md_p2[2] <= mid3(p31, p32, p33);
    lo_p2[2] <= min3(p31, p32, p33);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_p2  <= 1'b0;
      hr_p2  <= 1'b0;
      vld_p2 <= 1'b0;
      bdr_p2 <= 1'b0;
    end else begin
      vs_p2  <= vs_p1;
      hr_p2  <= hr_p1;
      vld_p2 <= vld_p1;
      bdr_p2 <= bdr_p1;
    end
  end

  // ---- S3: column reduction of the row triples ----
  pix_t med_a_p3, med_b_p3, med_c_p3, mn_p3, mx_p3, img_p3;
  logic vs_p3, hr_p3, vld_p3, bdr_p3;

  always_ff @(posedge clk) begin
    img_p3   <= img_p2;
    med_a_p3 <= min3(hi_p2[0], hi_p2[1], hi_p2[2]);
    med_b_p3 <= mid3(md_p2[0], md_p2[1], md_p2[2]);
    med_c_p3 <= max3(lo_p2[0], lo_p2[1], lo_p2[2]);
    mn_p3    <= min3(lo_p2[0], lo_p2[1], lo_p2[2]);
    mx_p3    <= max3(hi_p2[0], hi_p2[1], hi_p2[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_p3  <= 1'b0;
      hr_p3  <= 1'b0;
      vld_p3 <= 1'b0;
      bdr_p3 <= 1'b0;
    end else begin
      vs_p3  <= vs_p2;
      hr_p3  <= hr_p2;
      vld_p3 <= vld_p2;
      bdr_p3 <= bdr_p2;
    end
  end

  // ---- S4: final median, mode/border select, href gating ----
  pix_t filt;

  always_comb begin
    filt = img_p3;
    case (cur_mode)
      2'd1:    filt = mid3(med_a_p3, med_b_p3, med_c_p3);
      2'd2:    filt = mn_p3;
      2'd3:    filt = mx_p3;
      default: filt = img_p3;
    endcase
    if (bdr_p3)
      filt = img_p3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos.frame_vsync <= 1'b0;
      pos.frame_href  <= 1'b0;
      pos.frame_clken <= 1'b0;
      pos.img         <= '0;
    end else begin
      pos.frame_vsync <= vs_p3;
      pos.frame_href  <= hr_p3;
      pos.frame_clken <= vld_p3;
      pos.img         <= hr_p3 ? filt : '0;
    end
  end
endmodule

// File: tb/tb_vip_gray_rank_filter_3x3.sv
// Directed bench for vip_gray_rank_filter_3x3: 8x6 frames checked per cycle
// against a sorting reference, plus hand-computed spot values and counts.
`timescale 1ns/1ps
module tb_vip_gray_rank_filter_3x3;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] cur_mode;

  always #5 clk = ~clk;

  vip_gray_rank_filter_3x3_if #(.DW(DW)) pe_if ();
  vip_gray_rank_filter_3x3_if #(.DW(DW)) pos_if ();

  vip_gray_rank_filter_3x3 #(.DW(DW), .IMG_WIDTH(W), .LAT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .pe       (pe_if),
    .pos      (pos_if),
    .cur_mode (cur_mode)
  );

  logic [7:0] img [H][W];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // history of what was sampled at each edge, with the output it should produce
  logic       h_vs  [64];
  logic       h_hr  [64];
  logic       h_ce  [64];
  logic       h_chk [64];
  logic [7:0] h_exp [64];
  int         h_r   [64];
  int         h_c   [64];

  int         cur_r, cur_c, fm;
  logic [1:0] exp_cm;
  logic       prev_vs;
  int         cnt_ce, cnt_ff;
  logic [7:0] got45;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int r, input int c, input int m);
    logic [7:0] v [9];
    logic [7:0] t;
    int n;
    if (m == 0 || r < 2 || c < 2) return img[r][c];
    n = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v[n] = img[r-2+dr][c-2+dc];
        n = n + 1;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    if (m == 1) return v[4];
    if (m == 2) return v[0];
    return v[8];
  endfunction

  task automatic step();
    int k, j;
    @(posedge clk);
    #1;
    k = cyc & 63;
    h_vs[k] = pe_if.frame_vsync;
    h_hr[k] = pe_if.frame_href;
    h_ce[k] = pe_if.frame_clken;
    h_r[k]  = cur_r;
    h_c[k]  = cur_c;
    h_chk[k] = 1'b1;
    if (!pe_if.frame_href)       h_exp[k] = 8'h00;
    else if (fm == 0)            h_exp[k] = pe_if.img;
    else if (pe_if.frame_clken)  h_exp[k] = ref_pix(cur_r, cur_c, fm);
    else begin
      h_exp[k] = 8'h00;
      h_chk[k] = 1'b0;
    end
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        j = (cyc - d) & 63;
        h_vs[j] = 1'b0; h_hr[j] = 1'b0; h_ce[j] = 1'b0;
        h_exp[j] = 8'h00; h_chk[j] = 1'b1; h_r[j] = -1;
      end
      exp_cm  = 2'd0;
      prev_vs = 1'b0;
    end else begin
      if (pe_if.frame_vsync && !prev_vs) exp_cm = mode;
      prev_vs = pe_if.frame_vsync;
    end
    j = (cyc - 3) & 63;
    chk("vsync", 16'(pos_if.frame_vsync), 16'(h_vs[j]));
    chk("href", 16'(pos_if.frame_href), 16'(h_hr[j]));
    chk("clken", 16'(pos_if.frame_clken), 16'(h_ce[j]));
    if (h_chk[j]) chk("img", 16'(pos_if.img), 16'(h_exp[j]));
    chk("cur_mode", 16'(cur_mode), 16'(exp_cm));
    if (pos_if.frame_clken && pos_if.frame_href) begin
      cnt_ce++;
      if (pos_if.img == 8'hFF) cnt_ff++;
    end
    if (h_ce[j] && h_hr[j] && h_r[j] == 4 && h_c[j] == 5) got45 = pos_if.img;
    cyc++;
  endtask

  task automatic idle_line_gap();
    pe_if.frame_href  = 1'b0;
    pe_if.frame_clken = 1'b0;
    pe_if.img         = 8'h00;
    cur_r = -1; cur_c = -1;
    repeat (3) step();
  endtask

  task automatic vsync_pulse();
    pe_if.frame_vsync = 1'b1; step();
    pe_if.frame_vsync = 1'b0; step(); step();
  endtask

  // m<0 keeps the current mode input; sw_row>=0 changes the mode input mid-frame
  task automatic run_frame(input int m, input bit gap, input int sw_row, input int sw_mode);
    cnt_ce = 0; cnt_ff = 0; got45 = 8'hxx;
    if (m >= 0) mode = 2'(m);
    fm = int'(mode);
    vsync_pulse();
    for (int r = 0; r < H; r++) begin
      if (r == sw_row) mode = 2'(sw_mode);
      for (int c = 0; c < W; c++) begin
        pe_if.frame_href  = 1'b1;
        pe_if.frame_clken = 1'b1;
        pe_if.img         = img[r][c];
        cur_r = r; cur_c = c;
        step();
        if (gap) begin
          pe_if.frame_clken = 1'b0;
          pe_if.img         = 8'($urandom_range(0, 255));
          cur_r = -1; cur_c = -1;
          step();
        end
      end
      idle_line_gap();
    end
    repeat (6) step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      h_vs[i] = 1'b0; h_hr[i] = 1'b0; h_ce[i] = 1'b0;
      h_chk[i] = 1'b1; h_exp[i] = 8'h00; h_r[i] = -1; h_c[i] = -1;
    end
    rst = 1'b1; mode = 2'd0; fm = 0; exp_cm = 2'd0; prev_vs = 1'b0;
    cur_r = -1; cur_c = -1; cnt_ce = 0; cnt_ff = 0; got45 = 8'h00;
    pe_if.frame_vsync = 1'b0; pe_if.frame_href = 1'b0;
    pe_if.frame_clken = 1'b0; pe_if.img = 8'h00;
    repeat (3) step();
    chk("reset_href", 16'(pos_if.frame_href), 16'd0);
    chk("reset_img", 16'(pos_if.img), 16'd0);
    chk("reset_cur_mode", 16'(cur_mode), 16'd0);
    rst = 1'b0;
    step();

    // flat field, median
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'h55;
    run_frame(1, 1'b0, -1, 0);
    chk("flat_clken_count", 16'(cnt_ce), 16'd48);
    chk("flat_cur_mode", 16'(cur_mode), 16'd1);

    // impulse noise: median removes it, max spreads it over 9 outputs
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'h10;
    img[3][4] = 8'hFF;
    run_frame(1, 1'b0, -1, 0);
    chk("impulse_median_ff", 16'(cnt_ff), 16'd0);
    run_frame(3, 1'b0, -1, 0);
    chk("impulse_max_ff", 16'(cnt_ff), 16'd9);

    // ramp: window rows 2-4, cols 3-5 around output (4,5)
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(r * 8 + c);
    run_frame(2, 1'b0, -1, 0);
    chk("ramp_min_45", 16'(got45), 16'd19);
    run_frame(3, 1'b0, -1, 0);
    chk("ramp_max_45", 16'(got45), 16'd37);

    // mode input switched to min at row 2; frame stays median
    run_frame(1, 1'b0, 2, 2);
    chk("latch_median_45", 16'(got45), 16'd28);
    chk("latch_cur_mode_old", 16'(cur_mode), 16'd1);
    run_frame(-1, 1'b0, -1, 0);
    chk("latch_cur_mode_new", 16'(cur_mode), 16'd2);
    chk("latch_min_45", 16'(got45), 16'd19);

    // bypass
    run_frame(0, 1'b0, -1, 0);
    chk("bypass_45", 16'(got45), 16'd37);
    chk("bypass_clken_count", 16'(cnt_ce), 16'd48);

    // partial frame interrupted by a one-cycle reset mid-line
    mode = 2'd1; fm = 1;
    vsync_pulse();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < ((r == 0) ? W : 4); c++) begin
        pe_if.frame_href = 1'b1; pe_if.frame_clken = 1'b1;
        pe_if.img = img[r][c]; cur_r = r; cur_c = c;
        step();
        if (r == 0 && c == W - 1) idle_line_gap();
      end
    pe_if.img = img[1][4]; cur_r = 1; cur_c = 4;
    rst = 1'b1;
    step();
    chk("midrst_vsync", 16'(pos_if.frame_vsync), 16'd0);
    chk("midrst_href", 16'(pos_if.frame_href), 16'd0);
    chk("midrst_clken", 16'(pos_if.frame_clken), 16'd0);
    chk("midrst_img", 16'(pos_if.img), 16'd0);
    chk("midrst_cur_mode", 16'(cur_mode), 16'd0);
    rst = 1'b0;
    idle_line_gap();
    repeat (3) step();

    // stalled frame: clken toggles 1,0,1,0 on every line
    run_frame(1, 1'b1, -1, 0);
    chk("stall_median_45", 16'(got45), 16'd28);
    chk("stall_clken_count", 16'(cnt_ce), 16'd48);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
